ifid_issue_ctrl: RTL and testbench

- Hazard and issue controller for the IF/ID pipeline buffer of the FPU pipeline.
- Watches the instruction decoded from the IF/ID buffer and tracks in-flight FPU ops (ADD/MUL/DIV, each with a fixed latency) in a per-register scoreboard.
- Generates stall (hold IF/ID buffer and PC) and flush (bubble the buffer), and issues ops only when no RAW, WAW, divider or write-back-port conflict exists.

---
 rtl/fpu_pipe_pkg.sv | 29 ++
 rtl/fpu_scoreboard.sv | 47 ++++
 rtl/ifid_issue_ctrl.sv | 104 ++++++++++
 tb/tb_ifid_issue_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pipe_pkg.sv
// Shared FPU pipeline definitions: opcodes, latencies and register-file geometry.
package fpu_pipe_pkg;

   localparam int NREGS   = 16;
   localparam int REGW    = 4;
   localparam int CNTW    = 4;
   localparam int LAT_ADD = 3;
   localparam int LAT_MUL = 4;
   localparam int LAT_DIV = 8;
   localparam int ISIZE   = 32;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_MUL = 2'b01,
      OP_DIV = 2'b10,
      OP_NOP = 2'b11
   } op_e;

   function automatic logic [CNTW-1:0] lat_of(input op_e op);
      case (op)
         OP_ADD:  lat_of = CNTW'(LAT_ADD);
         OP_MUL:  lat_of = CNTW'(LAT_MUL);
         OP_DIV:  lat_of = CNTW'(LAT_DIV);
         OP_NOP:  lat_of = {CNTW{1'b0}};
         default: lat_of = {CNTW{1'b0}};
      endcase
   endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// Per-register countdown scoreboard: a register is busy until its counter reaches zero.
module fpu_scoreboard
   import fpu_pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en_i,
   input  logic [REGW-1:0]  set_idx_i,
   input  logic [CNTW-1:0]  set_val_i,
   output logic [NREGS-1:0] busy_vec_o
);

   logic [CNTW-1:0] cnt_q [NREGS];
   logic [CNTW-1:0] cnt_d [NREGS];

   // Decrement every live counter; a new issue overrides the decrement.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         if (set_en_i && (set_idx_i == REGW'(r))) begin
            cnt_d[r] = set_val_i;
         end else if (cnt_q[r] != {CNTW{1'b0}}) begin
            cnt_d[r] = cnt_q[r] - CNTW'(1);
         end else begin
            cnt_d[r] = {CNTW{1'b0}};
         end
      end
   end

   // Counter state register.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREGS; r++) begin
         if (rst) begin
            cnt_q[r] <= {CNTW{1'b0}};
         end else begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   // Busy flags straight from the counter state.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         busy_vec_o[r] = (cnt_q[r] != {CNTW{1'b0}});
      end
   end

endmodule

// File: rtl/ifid_issue_ctrl.sv
// IF/ID hazard and issue control: RAW/WAW via the scoreboard, divider occupancy
// and a write-back port reservation shift register.
module ifid_issue_ctrl
   import fpu_pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [1:0]       id_op,
   input  logic [REGW-1:0]  id_src1,
   input  logic [REGW-1:0]  id_src2,
   input  logic [REGW-1:0]  id_dst,
   input  logic             id_wr,
   input  logic             flush_req,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             issue_valid,
   output logic [NREGS-1:0] busy_vec,
   output logic             div_busy
);

   if (LAT_DIV > (2 ** CNTW) - 1) begin : g_lat_chk
      $error("LAT_DIV does not fit in the scoreboard counter width");
   end

   op_e             op_s;
   logic [CNTW-1:0] lat_s;
   logic            is_nop_s;
   logic            wr_s;
   logic            raw_s;
   logic            waw_s;
   logic            sdiv_s;
   logic            swb_s;
   logic            wb_set_s;
   logic [CNTW-1:0] div_cnt_q;
   logic [CNTW-1:0] div_cnt_d;
   logic [LAT_DIV:1] wb_resv_q;
   logic [LAT_DIV:1] wb_resv_d;

   assign op_s     = op_e'(id_op);
   assign lat_s    = lat_of(op_s);
   assign is_nop_s = (op_s == OP_NOP);
   // A NOP never writes, so it can never raise WAW or a write-back conflict.
   assign wr_s     = id_wr & ~is_nop_s;

   assign raw_s  = ~is_nop_s & (busy_vec[id_src1] | busy_vec[id_src2]);
   assign waw_s  = wr_s & busy_vec[id_dst];
   assign sdiv_s = (op_s == OP_DIV) & (div_cnt_q != {CNTW{1'b0}});

   // Write-back slot lookup at the op's own latency.
   always_comb begin
      swb_s = 1'b0;
      for (int i = 1; i <= LAT_DIV; i++) begin
         swb_s = swb_s | (wb_resv_q[i] & (lat_s == CNTW'(i)));
      end
      swb_s = swb_s & wr_s;
   end

   assign ifid_flush  = flush_req;
   assign ifid_stall  = id_valid & ~flush_req & (raw_s | waw_s | sdiv_s | swb_s);
   assign issue_valid = id_valid & ~flush_req & ~ifid_stall & ~is_nop_s;
   assign div_busy    = (div_cnt_q != {CNTW{1'b0}});
   assign wb_set_s    = issue_valid & wr_s;

   fpu_scoreboard u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_en_i   (wb_set_s),
      .set_idx_i  (id_dst),
      .set_val_i  (lat_s),
      .busy_vec_o (busy_vec)
   );

   // Shift reservations toward slot 1; a new one lands at its post-shift slot.
   always_comb begin
      for (int i = 1; i < LAT_DIV; i++) begin
         wb_resv_d[i] = wb_resv_q[i+1] | (wb_set_s & (lat_s == CNTW'(i + 1)));
      end
      wb_resv_d[LAT_DIV] = 1'b0;
   end

   // Divider occupancy countdown.
   always_comb begin
      if (issue_valid && (op_s == OP_DIV)) begin
         div_cnt_d = CNTW'(LAT_DIV);
      end else if (div_cnt_q != {CNTW{1'b0}}) begin
         div_cnt_d = div_cnt_q - CNTW'(1);
      end else begin
         div_cnt_d = {CNTW{1'b0}};
      end
   end

   // Divider and reservation state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= {CNTW{1'b0}};
         wb_resv_q <= {LAT_DIV{1'b0}};
      end else begin
         div_cnt_q <= div_cnt_d;
         wb_resv_q <= wb_resv_d;
      end
   end

endmodule

// File: tb/tb_ifid_issue_ctrl.sv
// Directed and random checks of ifid_issue_ctrl against an absolute-time model:
// each register/divider has a cycle at which it becomes free, write-backs occupy cycles.
module tb_ifid_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [1:0]  id_op;
   logic [3:0]  id_src1;
   logic [3:0]  id_src2;
   logic [3:0]  id_dst;
   logic        id_wr;
   logic        flush_req;
   logic        ifid_stall;
   logic        ifid_flush;
   logic        issue_valid;
   logic [15:0] busy_vec;
   logic        div_busy;

   int checks   = 0;
   int failures = 0;

   int ready_at [16];
   int div_free;
   bit wb_taken [int];
   int cyc;

   ifid_issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_op       (id_op),
      .id_src1     (id_src1),
      .id_src2     (id_src2),
      .id_dst      (id_dst),
      .id_wr       (id_wr),
      .flush_req   (flush_req),
      .ifid_stall  (ifid_stall),
      .ifid_flush  (ifid_flush),
      .issue_valid (issue_valid),
      .busy_vec    (busy_vec),
      .div_busy    (div_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < 16; r++) ready_at[r] = 0;
      div_free = 0;
      wb_taken.delete();
   endtask

   function automatic int lat_m(input logic [1:0] op);
      case (op)
         2'd0:    return 3;
         2'd1:    return 4;
         2'd2:    return 8;
         default: return 0;
      endcase
   endfunction

   // One clock cycle: drive, compare against the model, clock, advance the model.
   task automatic step(input bit r_in, input bit v, input logic [1:0] op,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                       input bit w, input bit f, input int e_stall, input int e_issue);
      bit is_nop, wr, raw, waw, sdiv, swb, stall, issue;
      int lat;
      logic [15:0] bv;
      rst = r_in; id_valid = v; id_op = op; id_src1 = s1; id_src2 = s2;
      id_dst = d; id_wr = w; flush_req = f;
      #1;
      is_nop = (op == 2'd3);
      lat    = lat_m(op);
      wr     = w && !is_nop;
      raw    = !is_nop && ((cyc < ready_at[s1]) || (cyc < ready_at[s2]));
      waw    = wr && (cyc < ready_at[d]);
      sdiv   = (op == 2'd2) && (cyc < div_free);
      swb    = wr && wb_taken.exists(cyc + lat);
      stall  = v && !f && (raw || waw || sdiv || swb);
      issue  = v && !f && !stall && !is_nop;
      for (int r = 0; r < 16; r++) bv[r] = (cyc < ready_at[r]);
      chk("stall", 32'(ifid_stall), 32'(stall));
      chk("issue", 32'(issue_valid), 32'(issue));
      chk("flush", 32'(ifid_flush), 32'(f));
      chk("busy_vec", 32'(busy_vec), 32'(bv));
      chk("div_busy", 32'(div_busy), 32'(cyc < div_free));
      if (e_stall >= 0) chk("dir_stall", 32'(ifid_stall), 32'(e_stall));
      if (e_issue >= 0) chk("dir_issue", 32'(issue_valid), 32'(e_issue));
      @(posedge clk);
      #1;
      if (r_in) begin
         model_clear();
      end else if (issue) begin
         if (wr) begin
            ready_at[d] = cyc + lat + 1;
            wb_taken[cyc + lat] = 1'b1;
         end
         if (op == 2'd2) div_free = cyc + 8 + 1;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 2'd3, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_op = 2'd3; id_src1 = 4'd0; id_src2 = 4'd0;
      id_dst = 4'd0; id_wr = 1'b0; flush_req = 1'b0;
      cyc = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      idle(2);

      // RAW: MUL r3 <= r1,r2 then ADD r5 <= r3,r4
      step(0, 1, 2'd1, 4'd1, 4'd2, 4'd3, 1, 0, 0, 1);
      for (int i = 1; i <= 4; i++) step(0, 1, 2'd0, 4'd3, 4'd4, 4'd5, 1, 0, 1, 0);
      step(0, 1, 2'd0, 4'd3, 4'd4, 4'd5, 1, 0, 0, 1);
      idle(10);

      // Back-to-back independent, then WAW on r1
      step(0, 1, 2'd0, 4'd0, 4'd0, 4'd1, 1, 0, 0, 1);
      step(0, 1, 2'd0, 4'd10, 4'd11, 4'd2, 1, 0, 0, 1);
      step(0, 1, 2'd0, 4'd0, 4'd0, 4'd1, 1, 0, 1, 0);
      step(0, 1, 2'd0, 4'd0, 4'd0, 4'd1, 1, 0, 1, 0);
      step(0, 1, 2'd0, 4'd0, 4'd0, 4'd1, 1, 0, 0, 1);
      idle(10);

      // Divider structural: busy cycles 1..8, second DIV goes at cycle 9
      step(0, 1, 2'd2, 4'd0, 4'd0, 4'd6, 1, 0, 0, 1);
      for (int i = 1; i <= 8; i++) step(0, 1, 2'd2, 4'd0, 4'd0, 4'd7, 1, 0, 1, 0);
      step(0, 1, 2'd2, 4'd0, 4'd0, 4'd7, 1, 0, 0, 1);
      idle(12);

      // Write-back port: MUL r8 then ADD r9 both land on the same cycle
      step(0, 1, 2'd1, 4'd0, 4'd0, 4'd8, 1, 0, 0, 1);
      step(0, 1, 2'd0, 4'd0, 4'd0, 4'd9, 1, 0, 1, 0);
      step(0, 1, 2'd0, 4'd0, 4'd0, 4'd9, 1, 0, 0, 1);
      idle(10);

      // Flush overrides a hazard
      step(0, 1, 2'd1, 4'd1, 4'd2, 4'd3, 1, 0, 0, 1);
      step(0, 1, 2'd0, 4'd3, 4'd4, 4'd5, 1, 1, 0, 0);
      step(0, 1, 2'd0, 4'd3, 4'd4, 4'd5, 1, 0, 1, 0);
      idle(10);

      // Reset mid-operation, then a DIV issues at once
      step(0, 1, 2'd2, 4'd0, 4'd0, 4'd6, 1, 0, 0, 1);
      idle(2);
      step(1, 0, 2'd3, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);
      step(0, 1, 2'd2, 4'd0, 4'd0, 4'd6, 1, 0, 0, 1);
      idle(10);

      // Random traffic over a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(99, 0) < 2) ? 1'b1 : 1'b0,
              ($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0,
              2'($urandom_range(3, 0)),
              4'($urandom_range(7, 0)), 4'($urandom_range(7, 0)), 4'($urandom_range(7, 0)),
              ($urandom_range(9, 0) < 8) ? 1'b1 : 1'b0,
              ($urandom_range(9, 0) < 1) ? 1'b1 : 1'b0,
              -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
